// File: rtl/wb_apply.sv
// White-balance apply: per-channel gain multiply with round-half-up and saturation.
// Shadow gains and the enable are swapped only on the last pixel of a frame.
module wb_apply #(
   parameter logic [10:0] IMG_HDISP = 11'd1936,
   parameter logic [10:0] IMG_VDISP = 11'd1088,
   parameter int          GAIN_FRAC = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        per_img_clken,
   input  logic [23:0] per_img_data,
   input  logic [38:0] in_gain_r,
   input  logic [38:0] in_gain_g,
   input  logic [38:0] in_gain_b,
   input  logic        wb_en,
   output logic        post_img_clken,
   output logic [23:0] post_img_data,
   output logic        frame_done
);

   localparam logic [38:0] GAIN_ONE = 39'd1 << GAIN_FRAC;
   localparam logic [47:0] RND      = 48'd1 << (GAIN_FRAC - 1);

   logic [10:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic              last;
   logic [2:0][38:0]  in_gain;
   logic [2:0][38:0]  gain_q, gain_d, g0_q, g0_d;
   logic              en_q, en_d, en0_q, en0_d, en1_q, en1_d;
   logic              v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
   logic [23:0]       d0_q, d0_d, d1_q, d1_d, out_q, out_d;
   logic [2:0][47:0]  p1_q, p1_d;
   logic              done_q, done_d;
   logic [47:0]       q;

   assign in_gain = {in_gain_r, in_gain_g, in_gain_b};

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      gain_d  = gain_q;
      en_d    = en_q;
      out_d   = out_q;
      q       = '0;
      last    = per_img_clken && (h_cnt_q == IMG_HDISP - 11'd1)
                && (v_cnt_q == IMG_VDISP - 11'd1);

      if (per_img_clken) begin
         if (h_cnt_q == IMG_HDISP - 11'd1) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == IMG_VDISP - 11'd1) ? 11'd0 : v_cnt_q + 11'd1;
         end else begin
            h_cnt_d = h_cnt_q + 11'd1;
         end
      end

      done_d = last;
      // A zero gain input means "no new estimate": keep the previous one.
      if (last) begin
         for (int c = 0; c < 3; c++)
            if (in_gain[c] != '0) gain_d[c] = in_gain[c];
         en_d = wb_en;
      end

      // S0 snapshots the shadows so the boundary pixel keeps the old gains.
      v0_d  = per_img_clken;
      d0_d  = per_img_data;
      g0_d  = gain_q;
      en0_d = en_q;

      v1_d  = v0_q;
      d1_d  = d0_q;
      en1_d = en0_q;
      for (int c = 0; c < 3; c++)
         p1_d[c] = 48'(d0_q[c*8 +: 8]) * 48'(g0_q[c]) + RND;

      v2_d = v1_q;
      if (v1_q) begin
         for (int c = 0; c < 3; c++) begin
            q = p1_q[c] >> GAIN_FRAC;
            if (!en1_q)          out_d[c*8 +: 8] = d1_q[c*8 +: 8];
            else if (q > 48'd255) out_d[c*8 +: 8] = 8'hff;
            else                 out_d[c*8 +: 8] = q[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         gain_q  <= {3{GAIN_ONE}};
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         v0_q    <= 1'b0;
         d0_q    <= '0;
         g0_q    <= {3{GAIN_ONE}};
         en0_q   <= 1'b0;
         v1_q    <= 1'b0;
         d1_q    <= '0;
         en1_q   <= 1'b0;
         p1_q    <= '0;
         v2_q    <= 1'b0;
         out_q   <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         gain_q  <= gain_d;
         en_q    <= en_d;
         done_q  <= done_d;
         v0_q    <= v0_d;
         d0_q    <= d0_d;
         g0_q    <= g0_d;
         en0_q   <= en0_d;
         v1_q    <= v1_d;
         d1_q    <= d1_d;
         en1_q   <= en1_d;
         p1_q    <= p1_d;
         v2_q    <= v2_d;
         out_q   <= out_d;
      end
   end

   assign post_img_clken = v2_q;
   assign post_img_data  = out_q;
   assign frame_done     = done_q;

endmodule
